// File: rtl/sopc_bus_pkg.sv
// Shared definitions for the SoC memory bus arbiter: FSM encoding and bus defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sopc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_t;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;
  localparam logic [31:0] ADDR_CLR_DEFAULT = 32'h8000_0000;
  localparam int TIMEOUT_DEFAULT = 255;

  // Width of a master index; a single master still needs one bit to hold index 0.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sopc_bus_rr_arbiter.sv
// Combinational N-way round-robin picker: first requester at or after rr_ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when a pick is consumed.
// Ports: req (request vector), rr_ptr (search start), grant (one-hot),
//        grant_idx (binary index of grant), grant_vld (any request present).
module rr_arbiter
  import sopc_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_vld
);

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!grant_vld && req[IDX_W'(j)]) begin
        grant_vld            = 1'b1;
        grant_idx            = IDX_W'(j);
        grant[IDX_W'(j)]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sopc_bus_arbiter.sv
// N-master to 1-slave memory bus arbiter with round-robin grant and address remap.
// Latency: req seen in cycle 0 -> mem_req cycle 1 -> m_ready cycle 2 at the earliest (3-cycle occupancy).
// Backpressure: slave stalls via mem_ready; masters hold m_req until their m_ready pulse.
// Ports: clk, rst (async active-low); m_req/m_we/m_addr/m_wdata/m_mask packed per master;
//        m_rdata/m_ready back to masters; mem_* to the slave; bus_err only with SOPC_BUS_ARB_TIMEOUT_EN,
//        which adds a BUSY watchdog that completes the transaction with zero data after TIMEOUT cycles.
module sopc_bus_arbiter
  import sopc_bus_pkg::*;
#(
  parameter int                    NUM_MASTERS = 2,
  parameter int                    ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int                    MASK_WIDTH  = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_CLR    = ADDR_WIDTH'(ADDR_CLR_DEFAULT),
  parameter int                    TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*MASK_WIDTH-1:0] m_mask,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic [MASK_WIDTH-1:0]             mem_mask,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_ready
`ifdef SOPC_BUS_ARB_TIMEOUT_EN
  ,
  output logic                              bus_err
`endif
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  bus_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr;
  logic [NUM_MASTERS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_vld;

  logic [IDX_W-1:0]       gnt_idx_q;
  logic [NUM_MASTERS-1:0] gnt_oh_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [MASK_WIDTH-1:0]  mask_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   wd_hit;   // watchdog expiry in the current BUSY cycle

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req       (m_req),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_vld) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready || wd_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: request and completion are decoded from state; payload comes from registers.
  always_comb begin
    mem_req = (state_q == ST_BUSY);
    mem_we  = (state_q == ST_BUSY) && we_q;
    m_ready = (state_q == ST_RESP) ? gnt_oh_q : '0;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_mask  = mask_q;
  assign m_rdata   = rdata_q;

  // Payload is latched at grant time so the slave sees a stable request
  // even if the master changes or drops its inputs while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      rdata_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && arb_vld) begin
        gnt_idx_q <= arb_idx;
        gnt_oh_q  <= arb_grant;
        we_q      <= m_we[arb_idx];
        addr_q    <= m_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_CLR;
        wdata_q   <= m_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
        mask_q    <= m_mask[arb_idx*MASK_WIDTH +: MASK_WIDTH];
      end
      if (state_q == ST_BUSY && (mem_ready || wd_hit)) begin
        rdata_q <= mem_ready ? mem_rdata : '0;
      end
      if (state_q == ST_RESP) begin
        if (gnt_idx_q == IDX_W'(NUM_MASTERS - 1)) rr_ptr <= '0;
        else                                      rr_ptr <= gnt_idx_q + IDX_W'(1);
      end
    end
  end

`ifdef SOPC_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // Counter holds the number of BUSY cycles already spent; expiry on the TIMEOUT-th.
  assign wd_hit  = (state_q == ST_BUSY) && !mem_ready && (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign bus_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state_q == ST_BUSY) ? wd_cnt + CNT_W'(1) : '0;
      err_q  <= wd_hit;   // high only in the RESP cycle that follows expiry
    end
  end
`else
  logic unused_timeout;
  assign wd_hit         = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule
